// File: rtl/dmem_responder.sv
// Data-port responder: word RAM with byte-strobed stores and an in-order response queue.
// Each accepted request raises data_ok a fixed number of edges later, or on the next free edge if an older response is still waiting.
module dmem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = $clog2(QDEPTH) + 1;
   localparam int LAT_W = 4;
   localparam logic [LAT_W-1:0] LOAD_CNT = LAT_W'(LATENCY - 1);

   logic [31:0]      mem [DEPTH];
   logic             qValid [QDEPTH];
   logic             qIsStore [QDEPTH];
   logic [31:0]      qData [QDEPTH];
   logic [LAT_W-1:0] qCnt [QDEPTH];

   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] wordIdx;
   logic              push;
   logic              pop;
   logic              full;
   logic              unusedAddrBits;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Byte offset and bits above the array are dropped, so aliased addresses hit the same word.
   assign wordIdx        = addr[ADDR_W+1:2];
   assign unusedAddrBits = ^{addr[31:ADDR_W+2], addr[1:0]};

   assign full    = (count == CNT_W'(QDEPTH));
   assign addr_ok = rst & ~full;
   assign push    = req & addr_ok;
   assign pop     = qValid[rdPtr] && (qCnt[rdPtr] == '0);
   assign busy    = (count != '0);

   // Array contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (push && wr) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
               mem[wordIdx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         count   <= '0;
         data_ok <= 1'b0;
         rdata   <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            qValid[i]   <= 1'b0;
            qIsStore[i] <= 1'b0;
            qData[i]    <= '0;
            qCnt[i]     <= '0;
         end
      end else begin
         data_ok <= pop;
         if (pop) begin
            rdata <= qIsStore[rdPtr] ? '0 : qData[rdPtr];
         end
         // Load data is captured at acceptance, so a store on the previous edge is already visible.
         for (int i = 0; i < QDEPTH; i++) begin
            if (push && (wrPtr == PTR_W'(i))) begin
               qValid[i]   <= 1'b1;
               qIsStore[i] <= wr;
               qData[i]    <= wr ? '0 : mem[wordIdx];
               qCnt[i]     <= LOAD_CNT;
            end else if (pop && (rdPtr == PTR_W'(i))) begin
               qValid[i] <= 1'b0;
            end else if (qValid[i] && (qCnt[i] != '0)) begin
               qCnt[i] <= qCnt[i] - LAT_W'(1);
            end
         end
         if (push) begin
            wrPtr <= nextPtr(wrPtr);
         end
         if (pop) begin
            rdPtr <= nextPtr(rdPtr);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (!push && pop) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset and latency corner cases, and random traffic
// checked against a response-schedule model (each response lands at max(accept+LATENCY, previous+1)).
module tb_dmem_responder;

   localparam int LAT = 2;
   localparam int QD  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [3:0]  wstrb = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        addrOk, dataOk, busy;
   logic [31:0] rdata;

   logic        sReq = 1'b0;
   logic        sWr = 1'b0;
   logic [3:0]  sStrb = '0;
   logic [31:0] sAddr = '0;
   logic [31:0] sWdata = '0;
   logic        l1AddrOk, l1DataOk, l1Busy, l8AddrOk, l8DataOk, l8Busy;
   logic [31:0] l1Rdata, l8Rdata;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(10), .LATENCY(LAT), .QDEPTH(QD)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
      .addr_ok(addrOk), .data_ok(dataOk), .rdata(rdata), .busy(busy)
   );

   dmem_responder #(.ADDR_W(10), .LATENCY(1), .QDEPTH(2)) dutL1 (
      .clk(clk), .rst(rst), .req(sReq), .wr(sWr), .wstrb(sStrb), .addr(sAddr), .wdata(sWdata),
      .addr_ok(l1AddrOk), .data_ok(l1DataOk), .rdata(l1Rdata), .busy(l1Busy)
   );

   dmem_responder #(.ADDR_W(10), .LATENCY(8), .QDEPTH(4)) dutL8 (
      .clk(clk), .rst(rst), .req(sReq), .wr(sWr), .wstrb(sStrb), .addr(sAddr), .wdata(sWdata),
      .addr_ok(l8AddrOk), .data_ok(l8DataOk), .rdata(l8Rdata), .busy(l8Busy)
   );

   typedef struct {
      int          sched;
      logic [31:0] data;
   } resp_t;

   typedef struct {
      logic        req;
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        expAddrOk;
      logic        expDataOk;
      logic [31:0] expRdata;
      logic        expBusy;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          edgeNum = 0;
   int          lastSched = 0;
   resp_t       pendQ[$];
   logic [31:0] refMem [1024];
   logic        sampledAddrOk;
   logic        lastAccepted;
   vec_t        vecs [30];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic vec_t mkVec(input logic r, input logic w, input logic [3:0] s, input logic [31:0] a,
                                  input logic [31:0] d, input logic ao, input logic dk,
                                  input logic [31:0] rd, input logic b);
      vec_t v;
      v = '{r, w, s, a, d, ao, dk, rd, b};
      return v;
   endfunction

   // One clock of traffic on the main DUT; the model decides acceptance and the response schedule.
   task automatic applyStimulus(input logic r, input logic w, input logic [3:0] s,
                                input logic [31:0] a, input logic [31:0] d);
      logic        expAddrOk;
      logic        expDataOk;
      logic [31:0] expRdata;
      resp_t       e;
      int          idx;
      req = r; wr = w; wstrb = s; addr = a; wdata = d;
      #1;
      expAddrOk     = (pendQ.size() < QD);
      sampledAddrOk = addrOk;
      checkOutput("addrOk", 32'(addrOk), 32'(expAddrOk));
      lastAccepted = r && expAddrOk;
      @(posedge clk);
      edgeNum++;
      expDataOk = 1'b0;
      expRdata  = '0;
      if (pendQ.size() > 0 && pendQ[0].sched == edgeNum) begin
         expDataOk = 1'b1;
         expRdata  = pendQ[0].data;
         void'(pendQ.pop_front());
      end
      if (lastAccepted) begin
         idx     = int'(a[11:2]);
         e.sched = edgeNum + LAT;
         if (e.sched <= lastSched) e.sched = lastSched + 1;
         lastSched = e.sched;
         if (w) begin
            e.data = '0;
            for (int i = 0; i < 4; i++) if (s[i]) refMem[idx][8*i +: 8] = d[8*i +: 8];
         end else begin
            e.data = refMem[idx];
         end
         pendQ.push_back(e);
      end
      @(negedge clk);
      checkOutput("dataOk", 32'(dataOk), 32'(expDataOk));
      if (expDataOk) checkOutput("rdata", rdata, expRdata);
      checkOutput("busy", 32'(busy), 32'(pendQ.size() != 0));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        hR, hW, pending;
      logic [3:0]  hS;
      logic [31:0] hA, hD;
      int          tries, off1, off8, pulses1, pulses8;
      logic [31:0] r1, r8;

      vecs[0]  = mkVec(1, 1, 4'hF, 32'h14, 32'h11223344, 1, 0, 0, 1);
      vecs[1]  = mkVec(1, 0, 4'h0, 32'h14, 32'h0,        1, 0, 0, 1);
      vecs[2]  = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        0, 1, 0, 1);
      vecs[3]  = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        1, 1, 32'h11223344, 0);
      vecs[4]  = mkVec(1, 1, 4'h5, 32'h14, 32'hAABBCCDD, 1, 0, 0, 1);
      vecs[5]  = mkVec(1, 0, 4'h0, 32'h16, 32'h0,        1, 0, 0, 1);
      vecs[6]  = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        0, 1, 0, 1);
      vecs[7]  = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        1, 1, 32'h11BB33DD, 0);
      vecs[8]  = mkVec(1, 1, 4'hF, 32'h0,  32'h0,        1, 0, 0, 1);
      vecs[9]  = mkVec(1, 1, 4'hF, 32'h4,  32'h1,        1, 0, 0, 1);
      vecs[10] = mkVec(1, 1, 4'hF, 32'h8,  32'h2,        0, 1, 0, 1);
      vecs[11] = mkVec(1, 1, 4'hF, 32'h8,  32'h2,        1, 1, 0, 1);
      vecs[12] = mkVec(1, 1, 4'hF, 32'hC,  32'h3,        1, 0, 0, 1);
      vecs[13] = mkVec(1, 0, 4'h0, 32'h0,  32'h0,        0, 1, 0, 1);
      vecs[14] = mkVec(1, 0, 4'h0, 32'h0,  32'h0,        1, 1, 0, 1);
      vecs[15] = mkVec(1, 0, 4'h0, 32'h4,  32'h0,        1, 0, 0, 1);
      vecs[16] = mkVec(1, 0, 4'h0, 32'h8,  32'h0,        0, 1, 0, 1);
      vecs[17] = mkVec(1, 0, 4'h0, 32'h8,  32'h0,        1, 1, 1, 1);
      vecs[18] = mkVec(1, 0, 4'h0, 32'hC,  32'h0,        1, 0, 0, 1);
      vecs[19] = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        0, 1, 2, 1);
      vecs[20] = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        1, 1, 3, 0);
      vecs[21] = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 0, 0);
      vecs[22] = mkVec(1, 1, 4'hF, 32'h1C, 32'hCAFEF00D, 1, 0, 0, 1);
      vecs[23] = mkVec(1, 0, 4'h0, 32'h1C, 32'h0,        1, 0, 0, 1);
      vecs[24] = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        0, 1, 0, 1);
      vecs[25] = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        1, 1, 32'hCAFEF00D, 0);
      vecs[26] = mkVec(1, 1, 4'h0, 32'h1C, 32'hFFFFFFFF, 1, 0, 0, 1);
      vecs[27] = mkVec(1, 0, 4'h0, 32'h1C, 32'h0,        1, 0, 0, 1);
      vecs[28] = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        0, 1, 0, 1);
      vecs[29] = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        1, 1, 32'hCAFEF00D, 0);

      #1;
      checkOutput("resetDataOk", 32'(dataOk), 32'(0));
      checkOutput("resetRdata", rdata, 32'h0);
      checkOutput("resetBusy", 32'(busy), 32'(0));
      checkOutput("resetAddrOk", 32'(addrOk), 32'(0));
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 30; i++) begin
         applyStimulus(vecs[i].req, vecs[i].wr, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata);
         checkOutput($sformatf("vec%0d addrOk", i), 32'(sampledAddrOk), 32'(vecs[i].expAddrOk));
         checkOutput($sformatf("vec%0d dataOk", i), 32'(dataOk), 32'(vecs[i].expDataOk));
         if (vecs[i].expDataOk) checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].expRdata);
         checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
      end

      // Two loads in flight, then an asynchronous reset drops them.
      applyStimulus(1, 0, 4'h0, 32'h14, 32'h0);
      applyStimulus(1, 0, 4'h0, 32'h1C, 32'h0);
      req = 1'b0;
      rst = 1'b0;
      #1;
      pendQ.delete();
      lastSched = edgeNum;
      checkOutput("midResetDataOk", 32'(dataOk), 32'(0));
      checkOutput("midResetBusy", 32'(busy), 32'(0));
      checkOutput("midResetAddrOk", 32'(addrOk), 32'(0));
      repeat (2) begin
         @(negedge clk);
         checkOutput("inResetDataOk", 32'(dataOk), 32'(0));
         checkOutput("inResetAddrOk", 32'(addrOk), 32'(0));
      end
      rst = 1'b1;
      #1;
      checkOutput("releaseAddrOk", 32'(addrOk), 32'(1));
      repeat (6) applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1, 0, 4'h0, 32'h14, 32'h0);
      applyStimulus(1, 0, 4'h0, 32'h1C, 32'h0);
      applyStimulus(1, 0, 4'h0, 32'h8, 32'h0);
      repeat (5) applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);

      // Give words 0..15 known contents, then random traffic with held requests and aliased addresses.
      for (int w = 0; w < 16; w++) begin
         hD = $urandom;
         tries = 0;
         do begin
            applyStimulus(1, 1, 4'hF, 32'(w) << 2, hD);
            tries++;
         end while (!lastAccepted && tries < 10);
         checkOutput("preloadAccepted", 32'(lastAccepted), 32'(1));
      end
      pending = 1'b0;
      hR = 1'b0; hW = 1'b0; hS = '0; hA = '0; hD = '0;
      for (int n = 0; n < 400; n++) begin
         if (!pending) begin
            hR = ($urandom_range(0, 3) != 0);
            hW = 1'($urandom_range(0, 1));
            hS = 4'($urandom);
            hA = {20'($urandom), 6'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
            hD = $urandom;
         end
         applyStimulus(hR, hW, hS, hA, hD);
         pending = hR && !lastAccepted;
      end
      for (int n = 0; n < 20 && pendQ.size() != 0; n++) applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
      checkOutput("drained", 32'(pendQ.size()), 32'(0));

      // Latency extremes: store then a single load, measure edges from acceptance to data_ok.
      sReq = 1'b1; sWr = 1'b1; sStrb = 4'hF; sAddr = 32'h40; sWdata = 32'h5A5A1234;
      #1;
      checkOutput("l1StoreAddrOk", 32'(l1AddrOk), 32'(1));
      checkOutput("l8StoreAddrOk", 32'(l8AddrOk), 32'(1));
      @(posedge clk);
      #1 sReq = 1'b0;
      repeat (12) @(negedge clk);
      sReq = 1'b1; sWr = 1'b0; sAddr = 32'h41;
      #1;
      checkOutput("l1LoadAddrOk", 32'(l1AddrOk), 32'(1));
      checkOutput("l8LoadAddrOk", 32'(l8AddrOk), 32'(1));
      @(posedge clk);
      #1 sReq = 1'b0;
      off1 = -1; off8 = -1; pulses1 = 0; pulses8 = 0; r1 = '0; r8 = '0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk);
         #1;
         if (l1DataOk) begin
            pulses1++;
            if (off1 < 0) begin off1 = n; r1 = l1Rdata; end
         end
         if (l8DataOk) begin
            pulses8++;
            if (off8 < 0) begin off8 = n; r8 = l8Rdata; end
         end
      end
      checkOutput("l1Offset", 32'(off1), 32'(1));
      checkOutput("l8Offset", 32'(off8), 32'(8));
      checkOutput("l1Pulses", 32'(pulses1), 32'(1));
      checkOutput("l8Pulses", 32'(pulses8), 32'(1));
      checkOutput("l1Rdata", r1, 32'h5A5A1234);
      checkOutput("l8Rdata", r8, 32'h5A5A1234);
      checkOutput("l1Busy", 32'(l1Busy), 32'(0));
      checkOutput("l8Busy", 32'(l8Busy), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data port: accepts load/store requests on a request/acknowledge handshake and returns read data after a fixed latency.
- Stores are applied with byte strobes; loads return a full word.
- Sits between the pipeline's mem-stage access logic and the on-chip data RAM model.
- Used for simulation and FPGA bring-up; supports several outstanding requests and in-order responses.

Parameters:
ADDR_W, 10, word-address bits; array depth is 2**ADDR_W words
LATENCY, 2, clock edges from request acceptance to data_ok assertion; legal range 1..8
QDEPTH, 2, maximum outstanding requests, power of two, at least 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
req  input  1  request valid
wr  input  1  1 = store, 0 = load
wstrb  input  4  store byte enables, lane i maps to wdata[8i+7:8i]
addr  input  32  byte address
wdata  input  32  store data
addr_ok  output  1  request accepted this cycle when req is also high
data_ok  output  1  one-cycle response pulse
rdata  output  32  load data, valid only while data_ok is high
busy  output  1  at least one request outstanding

Behaviour:
- Reset, rst low, asynchronous:
  - Queue is emptied and all countdown counters are cleared.
  - data_ok=0, rdata=0, busy=0.
  - addr_ok is forced to 0 while rst is low.
  - Memory array contents are not reset.
- addr_ok = rst & ~full. It is combinational from the registered queue state only and has no path from req.
- Acceptance happens on a rising edge with req & addr_ok. The request must hold req, wr, wstrb, addr and wdata stable until accepted.
- Word index = addr[ADDR_W+1:2].
  - addr[1:0] and addr[31:ADDR_W+2] are ignored, so aliasing is legal.
  - Alignment is checked upstream.
- Store, at the acceptance edge:
  - Each byte lane with wstrb[i]=1 is written; other lanes are unchanged.
  - wstrb=0 is a legal no-op store and still receives a response.
- Load, at the acceptance edge:
  - The array word is sampled into the queue entry.
  - This ordering means a load accepted on the edge after a store to the same word returns the stored data.
- Queue entry contents: {is_store, data[31:0], cnt}. cnt is loaded with LATENCY-1 at push.
  - Every edge, each valid entry with cnt>0 decrements.
- Response rule:
  - When the head entry has cnt==0, it is popped on the next edge.
  - On that same edge, registered data_ok<=1 and rdata<=(is_store ? 0 : data).
  - Result: the data_ok pulse for a request accepted on edge k starts exactly after edge k+LATENCY, as long as no earlier response is still pending.
- At most one response per cycle; responses are strictly in acceptance order.
  - If the head is delayed by an earlier response, its response follows on the next free edge.
  - Countdown continues to saturate at 0 meanwhile.
- data_ok is high for exactly one cycle per accepted request. It may be high on consecutive cycles for back-to-back requests.
- rdata holds its last value when data_ok is low. The bench must only check rdata while data_ok is high.
- Full: when the count equals QDEPTH, addr_ok=0.
  - No bypass: a pop and a push on the same edge are allowed only if the queue was not full at the start of the cycle.
  - Simultaneous push and pop leaves the count unchanged.
- busy = (count != 0), registered-derived.
- Pointers are log2(QDEPTH) bits and wrap modulo QDEPTH. Count is log2(QDEPTH)+1 bits.
- Reset asserted mid-operation:
  - Outstanding responses are dropped and no data_ok is issued for them.
  - Stores already accepted remain in the array.

Test Plan:
- Reset, then preload word 5 = 0x11223344 through a store with wstrb=4'hF at addr 0x14. One cycle later, load addr 0x14 -> data_ok pulses exactly LATENCY=2 edges after load acceptance, rdata=0x11223344.
- Store wdata=0xAABBCCDD, wstrb=4'b0101 to addr 0x14, then load addr 0x16 -> rdata=0x11BB33DD (addr[1:0] ignored).
- Issue 4 back-to-back loads of words 0..3 holding 0,1,2,3, with QDEPTH=2 and LATENCY=2 -> addr_ok drops whenever 2 requests are outstanding. Exactly four data_ok pulses occur with rdata 0,1,2,3 in order, and busy drops one edge after the last pop.
- Store then immediate load to the same word on consecutive acceptance edges -> load returns the new data. The store's data_ok carries rdata=0.
- Pull rst low while 2 loads are outstanding -> data_ok=0, busy=0, addr_ok=0 immediately. After release, addr_ok=1, no stale data_ok appears, and previously stored words read back intact.
- Sweep LATENCY=1 and 8 with single requests -> the data_ok offset from acceptance edge equals LATENCY in both cases.
